// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler.
//   state_e   : two-state control (IDLE, GRANT)
//   MAX_BITS  : largest supported requester-index width
//   HOLD_W    : width of the tenure-length counter (saturates at 255)
//   hold_inc  : saturating increment for the tenure-length counter
package rr_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int MAX_BITS = 6;
    localparam int HOLD_W   = 8;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
        return (h == {HOLD_W{1'b1}}) ? h : h + 1'b1;
    endfunction

endpackage

// File: rtl/rr_onehot_dec.sv
// Binary to one-hot decoder: y_o = 1 << a_i.
// Ports:
//   a_i  in   BITS      binary index
//   y_o  out  1<<BITS   one-hot vector with bit a_i set
module rr_onehot_dec #(
    parameter int BITS = 3
) (
    input  logic [BITS-1:0]      a_i,
    output logic [(1<<BITS)-1:0] y_o
);

    localparam int N = 1 << BITS;

    assign y_o = {{(N-1){1'b0}}, 1'b1} << a_i;

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one resource between N = 1<<BITS requesters.
// A winner keeps the grant while its request stays high; with MAX_HOLD != 0 the
// tenure is revoked after MAX_HOLD cycles and the requester is blocked until it
// drops its request for at least one cycle. All outputs are registered.
// Ports:
//   clk      in   1     rising-edge clock
//   rst      in   1     asynchronous active-high reset
//   req      in   N     level request per requester
//   gnt      out  N     one-hot grant, zero when idle
//   gnt_id   out  BITS  index of current / last grant
//   gnt_vld  out  1     grant active (== |gnt)
//   timeout  out  1     one-cycle pulse when a tenure is revoked
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter  int BITS     = 3,
    parameter  int MAX_HOLD = 0,
    localparam int N        = 1 << BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [BITS-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    if (BITS < 1 || BITS > MAX_BITS) begin : g_bits_chk
        $error("rr_grant_scheduler: BITS=%0d outside 1..%0d", BITS, MAX_BITS);
    end
    if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_hold_chk
        $error("rr_grant_scheduler: MAX_HOLD=%0d outside 0..255", MAX_HOLD);
    end

    localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);

    // First set bit of elig at or after ptr, wrapping N-1 -> 0.
    // Result is {found, index}.
    function automatic logic [BITS:0] rr_pick(input logic [N-1:0]    elig,
                                              input logic [BITS-1:0] ptr);
        logic            found;
        logic [BITS-1:0] idx;
        logic [BITS-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + BITS'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    state_e          state_q, state_d;
    logic [BITS-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]    blocked_q, blocked_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [BITS-1:0] id_q, id_d;
    logic            vld_q, vld_d;
    logic            to_q, to_d;

    logic [N-1:0]    cur_oh;
    logic [N-1:0]    pick_oh;
    logic [N-1:0]    elig;
    logic [N-1:0]    pick_elig;
    logic [BITS-1:0] pick_ptr;
    logic [BITS:0]   pick_res;
    logic            pick_found;
    logic [BITS-1:0] pick_idx;
    logic            cur_req;
    logic            forced;
    logic            release_now;

    rr_onehot_dec #(.BITS(BITS)) u_dec_cur (
        .a_i (id_q),
        .y_o (cur_oh)
    );

    rr_onehot_dec #(.BITS(BITS)) u_dec_pick (
        .a_i (pick_idx),
        .y_o (pick_oh)
    );

    assign elig    = req & ~blocked_q;
    assign cur_req = |(req & cur_oh);
    assign forced  = (state_q == GRANT) && cur_req &&
                     (MAX_HOLD != 0) && (hold_q >= MAX_HOLD_V);
    assign release_now = (state_q == GRANT) && (!cur_req || forced);

    // On release the scan restarts just past the released id, and that id is
    // masked so a same-cycle re-request cannot win back-to-back.
    assign pick_elig  = release_now ? (elig & ~cur_oh) : elig;
    assign pick_ptr   = release_now ? (id_q + BITS'(1)) : ptr_q;
    assign pick_res   = rr_pick(pick_elig, pick_ptr);
    assign pick_found = pick_res[BITS];
    assign pick_idx   = pick_res[BITS-1:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        vld_d     = vld_q;
        to_d      = 1'b0;
        // A block lifts on any cycle the requester is low.
        blocked_d = (blocked_q & req) | (forced ? cur_oh : '0);

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    id_d    = pick_idx;
                    vld_d   = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = id_q + BITS'(1);
                    to_d  = forced;
                    if (pick_found) begin
                        gnt_d  = pick_oh;
                        id_d   = pick_idx;
                        vld_d  = 1'b1;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else begin
                    hold_d = hold_inc(hold_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            blocked_q <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            vld_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            blocked_q <= blocked_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            vld_q     <= vld_d;
            to_q      <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign gnt_vld = vld_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: three instances
//   main : BITS=3, MAX_HOLD=0
//   hold : BITS=3, MAX_HOLD=4
//   b1   : BITS=1, MAX_HOLD=0
module tb_rr_grant_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_m = '0;
    logic [7:0] req_h = '0;
    logic [1:0] req_b = '0;

    logic [7:0] gnt_m, gnt_h;
    logic [2:0] id_m, id_h;
    logic       vld_m, vld_h, to_m, to_h;
    logic [1:0] gnt_b;
    logic [0:0] id_b;
    logic       vld_b, to_b;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.BITS(3), .MAX_HOLD(0)) u_main (
        .clk(clk), .rst(rst), .req(req_m),
        .gnt(gnt_m), .gnt_id(id_m), .gnt_vld(vld_m), .timeout(to_m)
    );

    rr_grant_scheduler #(.BITS(3), .MAX_HOLD(4)) u_hold (
        .clk(clk), .rst(rst), .req(req_h),
        .gnt(gnt_h), .gnt_id(id_h), .gnt_vld(vld_h), .timeout(to_h)
    );

    rr_grant_scheduler #(.BITS(1), .MAX_HOLD(0)) u_b1 (
        .clk(clk), .rst(rst), .req(req_b),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .timeout(to_b)
    );

    typedef struct {
        bit         rst_first;
        int         dsel;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] observe(input int dsel);
        case (dsel)
            0:       return {gnt_m, id_m, vld_m, to_m};
            1:       return {gnt_h, id_h, vld_h, to_h};
            default: return {6'b0, gnt_b, 2'b0, id_b, vld_b, to_b};
        endcase
    endfunction

    task automatic check(input int dsel, input logic [7:0] eg, input logic [2:0] eid,
                         input logic ev, input logic eto, input string nm);
        logic [12:0] act;
        logic [12:0] exp;
        act = observe(dsel);
        exp = {eg, eid, ev, eto};
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                     nm, act[12:5], act[4:2], act[1], act[0], eg, eid, ev, eto);
        end
    endtask

    task automatic apply(input int dsel, input logic [7:0] r, input logic [7:0] eg,
                         input logic [2:0] eid, input logic ev, input logic eto,
                         input string nm);
        @(negedge clk);
        req_m = (dsel == 0) ? r : 8'h00;
        req_h = (dsel == 1) ? r : 8'h00;
        req_b = (dsel == 2) ? r[1:0] : 2'b00;
        @(posedge clk);
        #1;
        check(dsel, eg, eid, ev, eto, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req_m = '0;
        req_h = '0;
        req_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input bit rf, input int d, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic t);
        vec_t e;
        e.rst_first = rf; e.dsel = d; e.req = r; e.gnt = g; e.id = i; e.vld = v; e.to = t;
        vecs.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] all1;
        int         w;
        int         nx;

        // single request, held 10 cycles, then released
        add(1, 0, 8'h04, 8'h04, 3'd2, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 8'h04, 8'h04, 3'd2, 1, 0);
        add(0, 0, 8'h00, 8'h00, 3'd2, 0, 0);
        // wrap from 7 to 0, mid-tenure arrival waits, id held while idle
        add(0, 0, 8'h80, 8'h80, 3'd7, 1, 0);
        add(0, 0, 8'h80, 8'h80, 3'd7, 1, 0);
        add(0, 0, 8'h01, 8'h01, 3'd0, 1, 0);
        add(0, 0, 8'h81, 8'h01, 3'd0, 1, 0);
        add(0, 0, 8'h80, 8'h80, 3'd7, 1, 0);
        add(0, 0, 8'h00, 8'h00, 3'd7, 0, 0);
        add(0, 0, 8'h81, 8'h01, 3'd0, 1, 0);
        add(0, 0, 8'h80, 8'h80, 3'd7, 1, 0);
        // MAX_HOLD=4 on requester 5
        add(1, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h20, 8'h00, 3'd5, 0, 1);
        add(0, 1, 8'h20, 8'h00, 3'd5, 0, 0);
        add(0, 1, 8'h00, 8'h00, 3'd5, 0, 0);
        add(0, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        // forced release with a waiting requester: back-to-back handover
        add(0, 1, 8'h21, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h21, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h21, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h21, 8'h01, 3'd0, 1, 1);
        add(0, 1, 8'h21, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h20, 8'h00, 3'd0, 0, 0);
        add(0, 1, 8'h20, 8'h00, 3'd0, 0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // asynchronous reset mid-tenure with all requests high
        apply(0, 8'hFF, 8'h01, 3'd0, 1, 0, "pre_rst");
        apply(0, 8'hFF, 8'h01, 3'd0, 1, 0, "pre_rst_hold");
        #1;
        rst = 1'b1;
        #1;
        check(0, 8'h00, 3'd0, 0, 0, "async_rst");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            apply(vecs[i].dsel, vecs[i].req, vecs[i].gnt, vecs[i].id, vecs[i].vld,
                  vecs[i].to, $sformatf("vec%0d", i));
        end

        // all requesting, each winner holds 2 cycles: order 0..7,0 with no bubble
        do_reset();
        all1 = 8'hFF;
        apply(0, all1, 8'h01, 3'd0, 1, 0, "rr_start");
        for (int k = 0; k < 8; k++) begin
            w  = k;
            nx = (k + 1) % 8;
            apply(0, all1, 8'(1 << w), 3'(w), 1, 0, $sformatf("rr_hold%0d", w));
            apply(0, all1 & ~8'(1 << w), 8'(1 << nx), 3'(nx), 1, 0,
                  $sformatf("rr_next%0d", nx));
        end

        // BITS=1: strict alternation
        do_reset();
        apply(2, 8'h03, 8'h01, 3'd0, 1, 0, "b1_start");
        for (int k = 0; k < 6; k++) begin
            w  = k % 2;
            nx = 1 - w;
            apply(2, 8'h03 & ~8'(1 << w), 8'(1 << nx), 3'(nx), 1, 0,
                  $sformatf("b1_alt%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
